// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the board SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned SRAM_AW = 20;
    localparam int unsigned SRAM_DW = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } sram_arb_state_t;

    // Write wins unless a read is waiting and writes have already hit their streak limit.
    function automatic logic pick_write(input logic wr_req, input logic rd_req, input logic streak_hit);
        return wr_req && (!rd_req || !streak_hit);
    endfunction

endpackage

// File: rtl/sram_access_arbiter.sv
// One-at-a-time arbiter between the recorder write path and the DSP/player read path
// for the single-port 1Mx16 SRAM; every SRAM pin comes straight from a flop.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ACC_CYCLES    = 2,
    parameter int unsigned MAX_WR_STREAK = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_req,
    input  logic [SRAM_AW-1:0] i_wr_addr,
    input  logic [SRAM_DW-1:0] i_wr_data,
    output logic               o_wr_ack,
    input  logic               i_rd_req,
    input  logic [SRAM_AW-1:0] i_rd_addr,
    output logic [SRAM_DW-1:0] o_rd_data,
    output logic               o_rd_ack,
    output logic               o_busy,
    output logic [SRAM_AW-1:0] o_SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0] io_SRAM_DQ,
    output logic               o_SRAM_WE_N,
    output logic               o_SRAM_CE_N,
    output logic               o_SRAM_OE_N,
    output logic               o_SRAM_LB_N,
    output logic               o_SRAM_UB_N
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned STREAK_W = $clog2(MAX_WR_STREAK + 1);
    localparam logic [CNT_W-1:0]    ACC_LAST   = CNT_W'(ACC_CYCLES - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_SAT = {STREAK_W{1'b1}};

    sram_arb_state_t     state_q,    state_d;
    logic [CNT_W-1:0]    acc_cnt_q,  acc_cnt_d;
    logic [STREAK_W-1:0] streak_q,   streak_d;
    logic                dir_wr_q,   dir_wr_d;
    logic [SRAM_AW-1:0]  addr_q,     addr_d;
    logic [SRAM_DW-1:0]  wdata_q,    wdata_d;
    logic [SRAM_DW-1:0]  rd_data_q,  rd_data_d;
    logic                wr_ack_q,   wr_ack_d;
    logic                rd_ack_q,   rd_ack_d;
    logic                busy_q,     busy_d;
    logic                ce_n_q,     ce_n_d;
    logic                we_n_q,     we_n_d;
    logic                oe_n_q,     oe_n_d;
    logic                drive_en_q, drive_en_d;
    logic                grant_wr_s;

    // Next-state, grant decision and look-ahead strobe values.
    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        streak_d   = streak_q;
        dir_wr_d   = dir_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        wr_ack_d   = 1'b0;
        rd_ack_d   = 1'b0;
        grant_wr_s = pick_write(i_wr_req, i_rd_req, streak_q >= STREAK_MAX);

        case (state_q)
            S_IDLE: begin
                if (grant_wr_s) begin
                    state_d   = S_ACCESS;
                    acc_cnt_d = {CNT_W{1'b0}};
                    dir_wr_d  = 1'b1;
                    addr_d    = i_wr_addr;
                    wdata_d   = i_wr_data;
                    if (i_rd_req) begin
                        streak_d = (streak_q == STREAK_SAT) ? streak_q : streak_q + STREAK_W'(1);
                    end else begin
                        streak_d = {STREAK_W{1'b0}};
                    end
                end else if (i_rd_req) begin
                    state_d   = S_ACCESS;
                    acc_cnt_d = {CNT_W{1'b0}};
                    dir_wr_d  = 1'b0;
                    addr_d    = i_rd_addr;
                    streak_d  = {STREAK_W{1'b0}};
                end else begin
                    streak_d  = {STREAK_W{1'b0}};
                end
            end
            S_ACCESS: begin
                if (acc_cnt_q == ACC_LAST) begin
                    state_d = S_DONE;
                    if (dir_wr_q) begin
                        wr_ack_d  = 1'b1;
                    end else begin
                        rd_ack_d  = 1'b1;
                        rd_data_d = io_SRAM_DQ;
                    end
                end else begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are computed for the upcoming cycle so the pins can be plain flops.
        busy_d     = (state_d != S_IDLE);
        ce_n_d     = !busy_d;
        we_n_d     = !(dir_wr_d && (state_d == S_ACCESS) && (acc_cnt_d != {CNT_W{1'b0}}));
        oe_n_d     = !(!dir_wr_d && (state_d == S_ACCESS));
        drive_en_d = dir_wr_d && busy_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            acc_cnt_q  <= {CNT_W{1'b0}};
            streak_q   <= {STREAK_W{1'b0}};
            dir_wr_q   <= 1'b0;
            addr_q     <= {SRAM_AW{1'b0}};
            wdata_q    <= {SRAM_DW{1'b0}};
            rd_data_q  <= {SRAM_DW{1'b0}};
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            drive_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            streak_q   <= streak_d;
            dir_wr_q   <= dir_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            busy_q     <= busy_d;
            ce_n_q     <= ce_n_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            drive_en_q <= drive_en_d;
        end
    end

    assign io_SRAM_DQ  = drive_en_q ? wdata_q : {SRAM_DW{1'bz}};
    assign o_SRAM_ADDR = addr_q;
    assign o_SRAM_CE_N = ce_n_q;
    assign o_SRAM_LB_N = ce_n_q;
    assign o_SRAM_UB_N = ce_n_q;
    assign o_SRAM_WE_N = we_n_q;
    assign o_SRAM_OE_N = oe_n_q;
    assign o_wr_ack    = wr_ack_q;
    assign o_rd_ack    = rd_ack_q;
    assign o_rd_data   = rd_data_q;
    assign o_busy      = busy_q;

endmodule
